// File: rtl/bfs_route_engine.sv
// bfs_route_engine: loads an edge list into an adjacency matrix and answers shortest-hop queries by level-synchronous BFS.
// Latency: result at E0+c+1 for a target c hops away, E0+L+1 when level L expands to nothing, E0+1 for a bad id.
// Backpressure: edge beats are never stalled; a query is taken only in IDLE (q_ready high) and load wins over query.
// Build option DIRECTED_EN: when defined, each edge is stored one-way (source->destination); otherwise both ways.
module bfs_route_engine #(
  parameter int N_NODE = 16,
  parameter int ID_W   = 4,
  parameter int COST_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   source,
  input  logic [ID_W-1:0]   destination,
  input  logic              q_valid,
  input  logic [ID_W-1:0]   q_src,
  input  logic [ID_W-1:0]   q_dst,
  output logic              q_ready,
  output logic              out_valid,
  output logic [COST_W-1:0] cost,
  output logic              unreach
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEARCH, ST_DONE} state_t;

  // One extra bit so that N_NODE itself is representable for range checks.
  localparam logic [ID_W:0]     LP_NODES   = (ID_W+1)'(N_NODE);
  localparam logic [COST_W-1:0] LP_LVL_MAX = COST_W'(N_NODE - 1);

`ifdef DIRECTED_EN
  localparam bit LP_UNDIRECTED = 1'b0;
`else
  localparam bit LP_UNDIRECTED = 1'b1;
`endif

  state_t            r_state;
  state_t            w_state_nxt;

  // r_adj[i][j] set means node j is one hop from node i.
  logic [N_NODE-1:0] r_adj [N_NODE];
  logic [N_NODE-1:0] r_frontier;
  logic [N_NODE-1:0] r_visited;
  logic [N_NODE-1:0] r_dst_oh;
  logic [COST_W-1:0] r_level;
  logic              r_bad_q;
  logic              r_q_ready;
  logic              r_out_valid;
  logic [COST_W-1:0] r_cost;
  logic              r_unreach;

  logic [N_NODE-1:0] w_src_oh;
  logic [N_NODE-1:0] w_dst_oh;
  logic [N_NODE-1:0] w_qs_oh;
  logic [N_NODE-1:0] w_qd_oh;
  logic [N_NODE-1:0] w_row_set [N_NODE];
  logic [N_NODE-1:0] w_reach;
  logic [N_NODE-1:0] w_next;
  logic              w_edge_ok;
  logic              w_q_bad;
  logic              w_load_start;
  logic              w_adj_wr;
  logic              w_accept;
  logic              w_found;
  logic              w_empty;
  logic              w_finish;

  // Decode edge endpoints and query ids to one-hot; out-of-range ids decode to all-zero.
  always_comb begin
    w_src_oh = '0;
    w_dst_oh = '0;
    w_qs_oh  = '0;
    w_qd_oh  = '0;
    for (int i = 0; i < N_NODE; i++) begin
      w_src_oh[i] = ({1'b0, source}      == (ID_W+1)'(i));
      w_dst_oh[i] = ({1'b0, destination} == (ID_W+1)'(i));
      w_qs_oh[i]  = ({1'b0, q_src}       == (ID_W+1)'(i));
      w_qd_oh[i]  = ({1'b0, q_dst}       == (ID_W+1)'(i));
    end
    w_edge_ok = in_valid
              && ({1'b0, source} < LP_NODES)
              && ({1'b0, destination} < LP_NODES)
              && (source != destination);
    w_q_bad   = ({1'b0, q_src} >= LP_NODES) || ({1'b0, q_dst} >= LP_NODES);
  end

  // Bits to set in each adjacency row for the current edge beat (mirror when undirected).
  always_comb begin
    for (int i = 0; i < N_NODE; i++) begin
      w_row_set[i] = '0;
      if (w_edge_ok) begin
        if (w_src_oh[i]) begin
          w_row_set[i] = w_row_set[i] | w_dst_oh;
        end
        if (LP_UNDIRECTED && w_dst_oh[i]) begin
          w_row_set[i] = w_row_set[i] | w_src_oh;
        end
      end
    end
  end

  // One BFS level: union of frontier rows minus visited; decide hit / exhausted.
  always_comb begin
    w_reach = '0;
    for (int i = 0; i < N_NODE; i++) begin
      if (r_frontier[i]) begin
        w_reach = w_reach | r_adj[i];
      end
    end
    w_next   = w_reach & ~r_visited;
    w_found  = !r_bad_q && ((r_frontier & r_dst_oh) != '0);
    w_empty  = r_bad_q || (w_next == '0);
    w_finish = (r_state == ST_SEARCH) && (w_found || w_empty);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the load/accept strobes; an edge beat beats a query in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_start = 1'b0;
    w_adj_wr     = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt  = ST_LOAD;
          w_load_start = 1'b1;
          w_adj_wr     = 1'b1;
        end else if (q_valid) begin
          w_state_nxt = ST_SEARCH;
          w_accept    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          w_adj_wr = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (w_found || w_empty) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Adjacency matrix: wiped on the first beat of a load, that beat's edge written on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODE; i++) begin
        r_adj[i] <= '0;
      end
    end else if (w_adj_wr) begin
      for (int i = 0; i < N_NODE; i++) begin
        r_adj[i] <= (w_load_start ? '0 : r_adj[i]) | w_row_set[i];
      end
    end
  end

  // Search state: seeded on query accept, advanced one level per SEARCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frontier <= '0;
      r_visited  <= '0;
      r_dst_oh   <= '0;
      r_level    <= '0;
      r_bad_q    <= 1'b0;
    end else if (w_accept) begin
      r_frontier <= w_qs_oh;
      r_visited  <= w_qs_oh;
      r_dst_oh   <= w_qd_oh;
      r_level    <= '0;
      r_bad_q    <= w_q_bad;
    end else if ((r_state == ST_SEARCH) && !w_finish) begin
      r_frontier <= w_next;
      r_visited  <= r_visited | w_next;
      // A new level always adds unvisited nodes, so this cap is only a guard.
      if (r_level != LP_LVL_MAX) begin
        r_level <= r_level + 1'b1;
      end
    end
  end

  // Registered outputs: result captured on entry to DONE and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_cost      <= '0;
      r_unreach   <= 1'b0;
    end else begin
      r_q_ready   <= (w_state_nxt == ST_IDLE);
      r_out_valid <= w_finish;
      if (w_finish) begin
        if (w_found) begin
          r_cost    <= r_level;
          r_unreach <= 1'b0;
        end else begin
          r_cost    <= '0;
          r_unreach <= 1'b1;
        end
      end
    end
  end

  assign q_ready   = r_q_ready;
  assign out_valid = r_out_valid;
  assign cost      = r_cost;
  assign unreach   = r_unreach;

endmodule

// File: tb/tb_bfs_route_engine.sv
// Directed bench for bfs_route_engine: table of {graph, query, expected latency/cost/unreach} plus hand sequences.
// Runs with N_NODE=12 so out-of-range ids (12..15) fit on the 4-bit id ports.
// Expectations for one-way storage are selected with the same DIRECTED_EN define as the design.
module tb_bfs_route_engine;

  localparam int TB_N   = 12;
  localparam int ID_W   = 4;
  localparam int COST_W = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [ID_W-1:0]   source;
  logic [ID_W-1:0]   destination;
  logic              q_valid;
  logic [ID_W-1:0]   q_src;
  logic [ID_W-1:0]   q_dst;
  logic              q_ready;
  logic              out_valid;
  logic [COST_W-1:0] cost;
  logic              unreach;

  int n_vec;
  int n_bad;

  typedef struct {
    int gid;
    int a;
    int b;
  } edge_t;

  typedef struct {
    int gid;
    int qs;
    int qd;
    int lat;
    int cst;
    int unr;
  } qvec_t;

  edge_t etab[$];
  qvec_t qtab[$];

  bfs_route_engine #(
    .N_NODE (TB_N),
    .ID_W   (ID_W),
    .COST_W (COST_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .source      (source),
    .destination (destination),
    .q_valid     (q_valid),
    .q_src       (q_src),
    .q_dst       (q_dst),
    .q_ready     (q_ready),
    .out_valid   (out_valid),
    .cost        (cost),
    .unreach     (unreach)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_e(input int g, input int a, input int b);
    edge_t e;
    e.gid = g;
    e.a   = a;
    e.b   = b;
    etab.push_back(e);
  endtask

  task automatic add_q(input int g, input int s, input int d, input int lat, input int c, input int u);
    qvec_t v;
    v.gid = g;
    v.qs  = s;
    v.qd  = d;
    v.lat = lat;
    v.cst = c;
    v.unr = u;
    qtab.push_back(v);
  endtask

  task automatic load_graph(input int g);
    foreach (etab[i]) begin
      if (etab[i].gid == g) begin
        @(negedge clk);
        in_valid    = 1'b1;
        source      = 4'(etab[i].a);
        destination = 4'(etab[i].b);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Present one query; latency counted in rising edges after the accept edge E0.
  task automatic run_query(input string nm, input int s, input int d, input int lat, input int c, input int u);
    int got;
    got = 0;
    @(negedge clk);
    check({nm, " q_ready idle"}, 32'(q_ready), 1);
    q_valid = 1'b1;
    q_src   = 4'(s);
    q_dst   = 4'(d);
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    check({nm, " q_ready busy"}, 32'(q_ready), 0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        got = k;
        break;
      end
    end
    check({nm, " latency"}, 32'(got), 32'(lat));
    check({nm, " cost"}, 32'(cost), 32'(c));
    check({nm, " unreach"}, 32'(unreach), 32'(u));
    @(posedge clk);
    #1;
    check({nm, " pulse width"}, 32'(out_valid), 0);
    check({nm, " cost hold"}, 32'(cost), 32'(c));
  endtask

  initial begin
    int cur;
    int seen;
    n_vec       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    q_valid     = 1'b0;
    source      = '0;
    destination = '0;
    q_src       = '0;
    q_dst       = '0;

    // Graph 0: chain 0-1-2-3
    add_e(0, 0, 1); add_e(0, 1, 2); add_e(0, 2, 3);
    // Graph 1: two islands 0-1 and 4-5
    add_e(1, 0, 1); add_e(1, 4, 5);
    // Graph 2: 0-1-2-11 plus an out-of-range edge and a self-loop that must be dropped
    add_e(2, 0, 1); add_e(2, 1, 2); add_e(2, 12, 3); add_e(2, 3, 3); add_e(2, 2, 11);
    // Graph 3: full chain 0..11 (longest possible distance)
    for (int i = 0; i < TB_N - 1; i++) add_e(3, i, i + 1);

    //    gid src dst lat cost unr
    add_q(0, 0, 3, 4, 3, 0);
    add_q(0, 2, 2, 1, 0, 0);
    add_q(0, 1, 3, 3, 2, 0);
`ifdef DIRECTED_EN
    add_q(0, 3, 0, 1, 0, 1);
`else
    add_q(0, 3, 0, 4, 3, 0);
`endif
    add_q(1, 0, 5, 2, 0, 1);
    add_q(1, 4, 5, 2, 1, 0);
`ifdef DIRECTED_EN
    add_q(1, 5, 4, 1, 0, 1);
    add_q(2, 2, 0, 2, 0, 1);
    add_q(2, 2, 3, 2, 0, 1);
`else
    add_q(1, 5, 4, 2, 1, 0);
    add_q(2, 2, 0, 3, 2, 0);
    add_q(2, 2, 3, 3, 0, 1);
`endif
    add_q(2, 0, 11, 4, 3, 0);
    add_q(2, 11, 11, 1, 0, 0);
    add_q(2, 0, 12, 1, 0, 1);
    add_q(2, 13, 0, 1, 0, 1);
    add_q(2, 12, 12, 1, 0, 1);
    add_q(3, 0, 11, 12, 11, 0);
    add_q(3, 5, 7, 3, 2, 0);
`ifdef DIRECTED_EN
    add_q(3, 11, 0, 1, 0, 1);
`else
    add_q(3, 11, 0, 12, 11, 0);
`endif

    // Reset state
    #1;
    check("reset q_ready", 32'(q_ready), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset cost", 32'(cost), 0);
    check("reset unreach", 32'(unreach), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release q_ready before edge", 32'(q_ready), 0);
    @(posedge clk);
    #1;
    check("release q_ready after edge", 32'(q_ready), 1);

    // Table-driven queries, reloading the graph when the table moves to a new one
    cur = -1;
    foreach (qtab[i]) begin
      if (qtab[i].gid != cur) begin
        load_graph(qtab[i].gid);
        cur = qtab[i].gid;
      end
      run_query($sformatf("q%0d(g%0d %0d->%0d)", i, qtab[i].gid, qtab[i].qs, qtab[i].qd),
                qtab[i].qs, qtab[i].qd, qtab[i].lat, qtab[i].cst, qtab[i].unr);
    end

    // Edge beat and query together in IDLE: load wins, query dropped, old graph replaced
    load_graph(0);
    run_query("coll pre", 0, 3, 4, 3, 0);
    @(negedge clk);
    in_valid    = 1'b1;
    source      = 4'd5;
    destination = 4'd6;
    q_valid     = 1'b1;
    q_src       = 4'd0;
    q_dst       = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    q_valid  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("coll dropped query out_valid count", 32'(seen), 0);
    run_query("coll old edge gone", 0, 3, 1, 0, 1);
    run_query("coll new edge", 5, 6, 2, 1, 0);

    // Reset pulsed in the middle of a search
    load_graph(0);
    run_query("rst pre", 0, 3, 4, 3, 0);
    @(negedge clk);
    q_valid = 1'b1;
    q_src   = 4'd0;
    q_dst   = 4'd3;
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid out_valid", 32'(out_valid), 0);
    check("rst mid cost", 32'(cost), 0);
    check("rst mid unreach", 32'(unreach), 0);
    check("rst mid q_ready", 32'(q_ready), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst release q_ready before edge", 32'(q_ready), 0);
    @(posedge clk);
    #1;
    check("rst release q_ready after edge", 32'(q_ready), 1);
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst aborted search out_valid count", 32'(seen), 0);
    run_query("rst graph cleared", 0, 3, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bfs_route_engine.md
BFS_ROUTE_ENGINE -- requirements
Module: bfs_route_engine

Interface
REQ-001 SHALL have parameter N_NODE, default 16: number of stations; legal range 2..64.
REQ-002 SHALL have parameter ID_W, default 4: station id width; must be at least clog2(N_NODE).
REQ-003 SHALL have parameter COST_W, default 4: cost width; must be at least clog2(N_NODE).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: edge beat valid.
REQ-007 SHALL have port source, input, ID_W bits: edge endpoint A.
REQ-008 SHALL have port destination, input, ID_W bits: edge endpoint B.
REQ-009 SHALL have port q_valid, input, 1 bit: query request.
REQ-010 SHALL have port q_src, input, ID_W bits: query start station.
REQ-011 SHALL have port q_dst, input, ID_W bits: query target station.
REQ-012 SHALL have port q_ready, output, 1 bit: query accept window; registered; high only in IDLE.
REQ-013 SHALL have port out_valid, output, 1 bit: result strobe.
REQ-014 SHALL have port cost, output, COST_W bits: hop count.
REQ-015 SHALL have port unreach, output, 1 bit: target not reachable.

Function
REQ-016 SHALL implement states IDLE, LOAD, SEARCH, DONE.
- IDLE to LOAD: on in_valid.
- IDLE to SEARCH: on q_valid without in_valid.
- LOAD to IDLE: on in_valid low.
- SEARCH to DONE: on hit or empty expansion.
- DONE to IDLE: always.
REQ-017 SHALL, on the IDLE-to-LOAD edge, clear the whole N_NODE x N_NODE adjacency matrix and write the first beat's edge on that same edge; the written edge wins over the clear.
REQ-018 SHALL, in LOAD, write one edge per in_valid cycle.
REQ-019 SHALL ignore an edge beat if either endpoint is N_NODE or greater.
REQ-020 SHALL ignore an edge beat if source equals destination (self-loop).
REQ-021 SHALL retain the graph across any number of queries until the next load or reset.
REQ-022 SHALL, on the query-accept edge E0, load frontier={q_src}, visited={q_src}, level=0.
REQ-023 SHALL, each SEARCH cycle, declare a hit if q_dst is in the frontier.
REQ-024 SHALL, otherwise, compute next = (OR of the adjacency rows of all frontier nodes) AND NOT visited, then set frontier=next, visited|=next, level+1.
REQ-025 SHALL treat an empty next set as unreachable.
REQ-026 SHALL, on the edge entering DONE, register the result:
- hit: cost=level, unreach=0.
- unreachable: cost=0, unreach=1.
- out_valid is high for exactly one cycle, in DONE.
REQ-027 SHALL raise out_valid at edge E0+c+1 for a reachable target at distance c (c=0 when q_src==q_dst).
REQ-028 SHALL raise out_valid at edge E0+L+1 for an unreachable target, where L is the level whose expansion was empty.
REQ-029 SHALL, if q_src or q_dst is N_NODE or greater, return unreach=1 at E0+1.
REQ-030 SHALL, when in_valid and q_valid are both high in IDLE, give in_valid priority and discard the query with no result.
REQ-031 SHALL ignore q_valid outside IDLE.
REQ-032 SHALL ignore in_valid in SEARCH and DONE.
REQ-033 SHALL hold cost and unreach stable after DONE until the next DONE.
REQ-034 SHALL never let cost wrap; level is bounded by N_NODE-1.

Reset
REQ-035 SHALL, on rst_n low, asynchronously force: state IDLE, adjacency cleared, frontier/visited/level zero, out_valid=0, cost=0, unreach=0, q_ready=0.
REQ-036 SHALL set q_ready=1 on the first clock edge after rst_n release.
REQ-037 SHALL abort a load or search in progress when reset asserts mid-operation, with no out_valid for it.

Configuration
REQ-038 SHALL, with DIRECTED_EN defined, store each edge as source-to-destination only.
REQ-039 SHALL, without DIRECTED_EN, store each edge in both directions (undirected).

Verification
REQ-040 SHALL cover: load 0-1, 1-2, 2-3; query 0 to 3 -> out_valid at E0+4, cost=3, unreach=0.
REQ-041 SHALL cover: same graph, query 2 to 2 -> out_valid at E0+1, cost=0, unreach=0.
REQ-042 SHALL cover: load 0-1, 4-5; query 0 to 5 -> out_valid at E0+2, unreach=1, cost=0.
REQ-043 SHALL cover: with DIRECTED_EN, load 0-1, 1-2; query 2 to 0 -> unreach=1; without DIRECTED_EN, same stimulus -> cost=2.
REQ-044 SHALL cover: in_valid and q_valid both high in IDLE -> no out_valid for the query; new graph loaded; old edges gone on the next query.
REQ-045 SHALL cover: rst_n pulsed low during SEARCH -> outputs 0 immediately; no out_valid; q_ready=1 one edge after release.
